// File: rtl/wb_arbiter.sv
// Two-master Wishbone classic arbiter (instr m0, data m1) with per-CYC grant and ACK watchdog.
// Define WB_ARB_ROUND_ROBIN_EN for alternating conflict resolution (default: m1 has priority).
module wb_arbiter #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                m0_cyc,
    input  logic                m0_stb,
    input  logic                m0_we,
    input  logic [XLEN-1:0]     m0_adr,
    input  logic [XLEN-1:0]     m0_dat_w,
    input  logic [XLEN/8-1:0]   m0_sel,
    output logic                m0_ack,
    output logic                m0_err,
    output logic [XLEN-1:0]     m0_dat_r,
    input  logic                m1_cyc,
    input  logic                m1_stb,
    input  logic                m1_we,
    input  logic [XLEN-1:0]     m1_adr,
    input  logic [XLEN-1:0]     m1_dat_w,
    input  logic [XLEN/8-1:0]   m1_sel,
    output logic                m1_ack,
    output logic                m1_err,
    output logic [XLEN-1:0]     m1_dat_r,
    output logic                s_cyc,
    output logic                s_stb,
    output logic                s_we,
    output logic [XLEN-1:0]     s_adr,
    output logic [XLEN-1:0]     s_dat_w,
    output logic [XLEN/8-1:0]   s_sel,
    input  logic                s_ack,
    input  logic [XLEN-1:0]     s_dat_r,
    output logic [1:0]          grant
);

    localparam int WW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WW-1:0] WDOG_MAX = WW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE = 2'd0, G0 = 2'd1, G1 = 2'd2} state_t;

    state_t        state;
    logic [WW-1:0] wdog;
    logic          fire;
    logic          own_cyc;
    logic          oth_cyc;
    logic          pick_m1;

`ifdef WB_ARB_ROUND_ROBIN_EN
    logic last_m1;
    assign pick_m1 = !last_m1;
`else
    assign pick_m1 = 1'b1;
`endif

    assign own_cyc = grant[1] ? m1_cyc : m0_cyc;
    assign oth_cyc = grant[1] ? m0_cyc : m1_cyc;
    // s_cyc is only ever high while a master owns the port, so fire is owner-only.
    assign fire = (TIMEOUT_CYCLES != 0) && s_cyc && s_stb && !s_ack && (wdog == WDOG_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            grant <= 2'b00;
            wdog  <= '0;
`ifdef WB_ARB_ROUND_ROBIN_EN
            last_m1 <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    wdog <= '0;
                    if (m1_cyc && (!m0_cyc || pick_m1)) begin
                        state <= G1;
                        grant <= 2'b10;
`ifdef WB_ARB_ROUND_ROBIN_EN
                        last_m1 <= 1'b1;
`endif
                    end else if (m0_cyc) begin
                        state <= G0;
                        grant <= 2'b01;
`ifdef WB_ARB_ROUND_ROBIN_EN
                        last_m1 <= 1'b0;
`endif
                    end
                end
                default: begin
                    if (!own_cyc) begin
                        wdog <= '0;
                        if (oth_cyc) begin
                            // Direct handover, no idle bubble between owners.
                            state <= (state == G0) ? G1 : G0;
                            grant <= (state == G0) ? 2'b10 : 2'b01;
`ifdef WB_ARB_ROUND_ROBIN_EN
                            last_m1 <= (state == G0);
`endif
                        end else begin
                            state <= IDLE;
                            grant <= 2'b00;
                        end
                    end else if (fire) begin
                        state <= IDLE;
                        grant <= 2'b00;
                        wdog  <= '0;
                    end else if (s_ack) begin
                        wdog <= '0;
                    end else if (s_stb) begin
                        wdog <= wdog + 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        s_cyc    = 1'b0;
        s_stb    = 1'b0;
        s_we     = 1'b0;
        s_adr    = '0;
        s_dat_w  = '0;
        s_sel    = '0;
        m0_ack   = 1'b0;
        m0_err   = 1'b0;
        m0_dat_r = '0;
        m1_ack   = 1'b0;
        m1_err   = 1'b0;
        m1_dat_r = '0;
        if (grant[0]) begin
            s_cyc    = m0_cyc;
            s_stb    = m0_stb;
            s_we     = m0_we;
            s_adr    = m0_adr;
            s_dat_w  = m0_dat_w;
            s_sel    = m0_sel;
            m0_ack   = s_ack;
            m0_err   = fire;
            m0_dat_r = s_dat_r;
        end else if (grant[1]) begin
            s_cyc    = m1_cyc;
            s_stb    = m1_stb;
            s_we     = m1_we;
            s_adr    = m1_adr;
            s_dat_w  = m1_dat_w;
            s_sel    = m1_sel;
            m1_ack   = s_ack;
            m1_err   = fire;
            m1_dat_r = s_dat_r;
        end
    end

endmodule
